// File: rtl/manchester_tx_if.sv
// Byte/strobe input and encoded-line status outputs of the Manchester transmitter.
// The master side is the byte-assembly stage; the slave side is the transmitter.
interface manchester_tx_if;
    logic [7:0] data_in;
    logic       start;
    logic       manch_out;
    logic       busy;
    logic       done;

    modport master (
        output data_in,
        output start,
        input  manch_out,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  start,
        output manch_out,
        output busy,
        output done
    );
endinterface

// File: rtl/manchester_tx.sv
// Serializes one byte as start bit, data MSB first, optional even parity,
// Manchester encoded (IEEE 802.3) with HALF_BIT_CYCLES clocks per half-bit.
module manchester_tx #(
    parameter int HALF_BIT_CYCLES = 4,
    parameter bit PARITY_EN       = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    manchester_tx_if.slave   bus
);

    localparam int              CW       = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_MAX  = CW'(HALF_BIT_CYCLES - 1);
    localparam logic [3:0]      LAST_BIT = PARITY_EN ? 4'd9 : 4'd8;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t         state;
    logic [CW-1:0]  half_cnt;
    logic [3:0]     bit_idx;
    logic           phase;
    logic [7:0]     shreg;
    logic           parity_bit;
    logic           manch_q;
    logic           busy_q;
    logic           done_q;

    logic [CW-1:0]  nxt_cnt;
    logic [3:0]     nxt_idx;
    logic           nxt_phase;
    logic [7:0]     nxt_shreg;
    logic           nxt_bit;
    logic           nxt_line;
    logic           frame_end;

    // Position of the next half-bit; shreg[7] always holds the current data bit.
    always_comb begin
        nxt_cnt   = half_cnt;
        nxt_idx   = bit_idx;
        nxt_phase = phase;
        nxt_shreg = shreg;
        frame_end = 1'b0;
        if (half_cnt == CNT_MAX) begin
            nxt_cnt = '0;
            if (phase) begin
                nxt_phase = 1'b0;
                if (bit_idx == LAST_BIT) begin
                    frame_end = 1'b1;
                end else begin
                    nxt_idx = bit_idx + 4'd1;
                    if (bit_idx != 4'd0) begin
                        nxt_shreg = {shreg[6:0], 1'b0};
                    end
                end
            end else begin
                nxt_phase = 1'b1;
            end
        end else begin
            nxt_cnt = half_cnt + CW'(1);
        end

        if (nxt_idx == 4'd0) begin
            nxt_bit = 1'b1;
        end else if (nxt_idx == 4'd9) begin
            nxt_bit = parity_bit;
        end else begin
            nxt_bit = nxt_shreg[7];
        end
        nxt_line = nxt_phase ? nxt_bit : ~nxt_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            half_cnt   <= '0;
            bit_idx    <= 4'd0;
            phase      <= 1'b0;
            shreg      <= 8'd0;
            parity_bit <= 1'b0;
            manch_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state      <= SEND;
                        shreg      <= bus.data_in;
                        parity_bit <= ^bus.data_in;
                        half_cnt   <= '0;
                        bit_idx    <= 4'd0;
                        phase      <= 1'b0;
                        manch_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        manch_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                SEND: begin
                    if (frame_end) begin
                        state   <= DONE;
                        manch_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        half_cnt <= nxt_cnt;
                        bit_idx  <= nxt_idx;
                        phase    <= nxt_phase;
                        shreg    <= nxt_shreg;
                        manch_q  <= nxt_line;
                    end
                end
                default: begin
                    state   <= IDLE;
                    manch_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.manch_out = manch_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_manchester_tx.sv
// Bench for manchester_tx: three instances (H=4/parity, H=1/parity, H=2/no parity)
// compared cycle by cycle against a frame model built from the encoding rules.
module tb_manchester_tx;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    manchester_tx_if bus0 ();
    manchester_tx_if bus1 ();
    manchester_tx_if bus2 ();

    manchester_tx #(.HALF_BIT_CYCLES(4), .PARITY_EN(1'b1)) u0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    manchester_tx #(.HALF_BIT_CYCLES(1), .PARITY_EN(1'b1)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    manchester_tx #(.HALF_BIT_CYCLES(2), .PARITY_EN(1'b0)) u2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         exp_len;
        logic       exp_last_half;
        string      name;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   obs_len;
    int   obs_last_half;
    bit   exp_line[$];
    vec_t vecs[3];

    function automatic int h_of(input int idx);
        case (idx)
            0:       return 4;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic bit par_of(input int idx);
        return (idx != 2);
    endfunction

    // {manch_out, busy, done} of one instance
    function automatic logic [2:0] outs(input int idx);
        case (idx)
            0:       return {bus0.manch_out, bus0.busy, bus0.done};
            1:       return {bus1.manch_out, bus1.busy, bus1.done};
            default: return {bus2.manch_out, bus2.busy, bus2.done};
        endcase
    endfunction

    task automatic applyStimulus(input int idx, input logic s, input logic [7:0] d);
        case (idx)
            0:       begin bus0.start = s; bus0.data_in = d; end
            1:       begin bus1.start = s; bus1.data_in = d; end
            default: begin bus2.start = s; bus2.data_in = d; end
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Expected line, one entry per clock, from the frame bit list and 802.3 halves
    task automatic buildExpected(input int h, input bit par, input logic [7:0] d);
        logic [9:0] fb;
        int         count;
        bit         b;
        exp_line.delete();
        fb    = {1'b1, d, ^d};
        count = par ? 10 : 9;
        for (int k = 0; k < count; k++) begin
            b = fb[9-k];
            repeat (h) exp_line.push_back(~b);
            repeat (h) exp_line.push_back(b);
        end
    endtask

    // Called at a negedge; the following posedge is the accepting edge E.
    task automatic runFrame(input int idx, input logic [7:0] d, input bit hold,
                            input int poke_at, input int rst_at, input string tag);
        int         h;
        int         len;
        logic [2:0] o;
        logic       s;
        logic [7:0] dd;
        h = h_of(idx);
        buildExpected(h, par_of(idx), d);
        len           = exp_line.size();
        obs_len       = -1;
        obs_last_half = -1;
        applyStimulus(idx, 1'b1, d);
        @(posedge clk);
        for (int n = 0; n <= len; n++) begin
            @(negedge clk);
            o = outs(idx);
            if (n == rst_at) begin
                checkOutput($sformatf("%s reset_abort", tag), {29'd0, o}, 32'd0);
                rst = 1'b0;
                applyStimulus(idx, 1'b0, d);
                return;
            end
            if (o[0] && obs_len < 0) obs_len = n;
            if (n == len - 2*h) obs_last_half = int'(o[2]);
            if (n < len) begin
                checkOutput($sformatf("%s n=%0d", tag, n), {29'd0, o}, {29'd0, exp_line[n], 2'b10});
                s  = hold;
                dd = (poke_at >= 0 && n + 1 >= poke_at) ? ~d : d;
                if (n + 1 == poke_at) s = 1'b1;
                if (n + 1 == rst_at) begin
                    rst = 1'b1;
                    s   = 1'b1;
                end
                applyStimulus(idx, s, dd);
            end else begin
                checkOutput($sformatf("%s done_cycle", tag), {29'd0, o}, 32'd1);
            end
        end
        if (!hold) begin
            @(negedge clk);
            checkOutput($sformatf("%s after_done", tag), {29'd0, outs(idx)}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("reset_state dut%0d", i), {29'd0, outs(i)}, 32'd0);
        rst = 1'b0;

        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput($sformatf("idle c=%0d", c), {23'd0, outs(2), outs(1), outs(0)}, 32'd0);
        end

        vecs[0] = '{0, 8'hA5, 80, 1'b1, "a5_h4_par"};
        vecs[1] = '{1, 8'h01, 20, 1'b0, "01_h1_par"};
        vecs[2] = '{2, 8'hFF, 36, 1'b0, "ff_h2_nopar"};
        for (int i = 0; i < 3; i++) begin
            runFrame(vecs[i].idx, vecs[i].data, 1'b0, -1, -1, vecs[i].name);
            checkOutput($sformatf("%s done_edge", vecs[i].name), obs_len, vecs[i].exp_len);
            checkOutput($sformatf("%s last_bit_first_half", vecs[i].name), obs_last_half,
                        {31'd0, vecs[i].exp_last_half});
        end

        // Re-request with new data at E+10 must not disturb the running frame
        runFrame(0, 8'hA5, 1'b0, 10, -1, "poke");
        checkOutput("poke done_edge", obs_len, 80);

        // Reset at E+30 aborts silently; a later frame still works
        runFrame(0, 8'h5A, 1'b0, -1, 30, "abort");
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput($sformatf("post_abort c=%0d", c), {29'd0, outs(0)}, 32'd0);
        end
        runFrame(0, 8'hC3, 1'b0, -1, -1, "after_abort");

        runFrame(0, 8'h3C, 1'b1, -1, -1, "b2b0");
        runFrame(0, 8'h3C, 1'b1, -1, -1, "b2b1");
        runFrame(0, 8'h3C, 1'b0, -1, -1, "b2b2");

        for (int r = 0; r < 12; r++) begin
            int         idx;
            logic [7:0] d;
            idx = int'($urandom_range(0, 2));
            d   = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            runFrame(idx, d, 1'b0, -1, -1, $sformatf("rand%0d dut%0d d=%02h", r, idx, d));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
